// File: rtl/fly_pkg.sv
// fly_pkg: shared geometry, timing constants and FSM encoding for the fly swarm
package fly_pkg;
    localparam int FLY_COUNT      = 16;
    localparam int IW             = $clog2(FLY_COUNT);
    localparam int COLS           = 8;
    localparam int X0             = 64;
    localparam int Y0             = 40;
    localparam int PITCH_X        = 48;
    localparam int PITCH_Y        = 40;
    localparam int SPRITE         = 32;
    localparam int SCREEN_W       = 640;
    localparam int STEP           = 2;
    localparam int DROP           = 16;
    localparam int INVADE_Y       = 400;
    localparam int RESPAWN_FRAMES = 120;
    localparam int CW             = $clog2(RESPAWN_FRAMES + 1);
    typedef enum logic [2:0] {IDLE, SPAWN, WAIT, SCAN, MOVE, CLEAR, GAMEOVER} state_t;
endpackage

// File: rtl/fly_swarm_ctrl_if.sv
// fly_swarm_ctrl_if: kill-request handshake from collision logic to the swarm
interface fly_swarm_ctrl_if;
    logic                   hit_valid;
    logic [fly_pkg::IW-1:0] hit_idx;
    logic                   hit_ready;
    modport master (output hit_valid, hit_idx, input hit_ready);
    modport slave (input hit_valid, hit_idx, output hit_ready);
endinterface

// File: rtl/fly_pos_calc.sv
// fly_pos_calc: screen position of one fly from its formation slot and the swarm offset
module fly_pos_calc
    import fly_pkg::*;
(
    input  logic [IW-1:0]      idx,
    input  logic signed [10:0] off_x,
    input  logic signed [10:0] off_y,
    output logic [9:0]         x,
    output logic [9:0]         y
);
    assign x = 10'(X0 + (int'(idx) % COLS) * PITCH_X + int'(off_x));
    assign y = 10'(Y0 + (int'(idx) / COLS) * PITCH_Y + int'(off_y));
endmodule

// File: rtl/fly_swarm_ctrl.sv
// fly_swarm_ctrl: formation state, per-frame extent scan and edge bounce, kills,
// wave clear with delayed respawn, and invasion detection.
module fly_swarm_ctrl
    import fly_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    frame_tick,
    fly_swarm_ctrl_if.slave         hit,
    output logic [10*FLY_COUNT-1:0] fly_x_flat,
    output logic [10*FLY_COUNT-1:0] fly_y_flat,
    output logic [FLY_COUNT-1:0]    fly_alive,
    output logic                    wave_clear,
    output logic                    invaded
);
    state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [9:0] min_x, min_n, max_x, max_n, max_y, maxy_n;
    logic signed [10:0] off_x, offx_n, off_y, offy_n;
    logic dir, dir_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [FLY_COUNT-1:0] alive_n;
    logic [9:0] fx [FLY_COUNT];
    logic [9:0] fy [FLY_COUNT];
    logic [9:0] px [FLY_COUNT];
    logic [9:0] py [FLY_COUNT];
    logic load, wc_n, inv_n, ready, bounce, hit_ok;

    // positions are computed from the next offsets so SPAWN/MOVE reload in one cycle
    for (genvar i = 0; i < FLY_COUNT; i++) begin : g_fly
        fly_pos_calc u_pos (.idx(IW'(i)), .off_x(offx_n), .off_y(offy_n), .x(px[i]), .y(py[i]));
        assign fly_x_flat[10*i +: 10] = fx[i];
        assign fly_y_flat[10*i +: 10] = fy[i];
    end

    assign hit.hit_ready = ready;
    assign hit_ok = hit.hit_valid && ready && fly_alive[hit.hit_idx];
    // dir=1 means the formation is moving left
    assign bounce = dir ? (int'(min_x) < STEP) : (int'(max_x) + STEP > SCREEN_W - SPRITE);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        min_n   = min_x;
        max_n   = max_x;
        maxy_n  = max_y;
        offx_n  = off_x;
        offy_n  = off_y;
        dir_n   = dir;
        cnt_n   = cnt;
        alive_n = fly_alive;
        wc_n    = 1'b0;
        inv_n   = invaded;
        load    = 1'b0;
        case (state)
            IDLE, GAMEOVER: state_n = start ? SPAWN : state;
            SPAWN: begin
                offx_n  = '0;
                offy_n  = '0;
                dir_n   = 1'b0;
                alive_n = '1;
                inv_n   = 1'b0;
                load    = 1'b1;
                state_n = WAIT;
            end
            WAIT: if (frame_tick) begin
                state_n = SCAN;
                idx_n   = '0;
                min_n   = '1;
                max_n   = '0;
                maxy_n  = '0;
            end
            SCAN: begin
                if (fly_alive[idx]) begin
                    min_n  = fx[idx] < min_x ? fx[idx] : min_x;
                    max_n  = fx[idx] > max_x ? fx[idx] : max_x;
                    maxy_n = fy[idx] > max_y ? fy[idx] : max_y;
                end
                idx_n   = idx + 1'b1;
                state_n = idx == IW'(FLY_COUNT - 1) ? MOVE : SCAN;
            end
            MOVE: begin
                dir_n   = bounce ? ~dir : dir;
                offy_n  = bounce ? off_y + 11'(DROP) : off_y;
                offx_n  = bounce ? off_x : dir ? off_x - 11'(STEP) : off_x + 11'(STEP);
                load    = 1'b1;
                inv_n   = int'(max_y) + (bounce ? DROP : 0) >= INVADE_Y;
                state_n = inv_n ? GAMEOVER : WAIT;
            end
            CLEAR: if (frame_tick) begin
                cnt_n   = cnt + 1'b1;
                state_n = int'(cnt) + 1 == RESPAWN_FRAMES ? SPAWN : CLEAR;
            end
            default: state_n = IDLE;
        endcase
        if (hit_ok) begin
            alive_n[hit.hit_idx] = 1'b0;
            if (alive_n == '0) begin
                wc_n    = 1'b1;
                state_n = CLEAR;
                cnt_n   = '0;
                inv_n   = invaded;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            min_x      <= '1;
            max_x      <= '0;
            max_y      <= '0;
            off_x      <= '0;
            off_y      <= '0;
            dir        <= 1'b0;
            cnt        <= '0;
            fly_alive  <= '0;
            wave_clear <= 1'b0;
            invaded    <= 1'b0;
            ready      <= 1'b0;
            for (int i = 0; i < FLY_COUNT; i++) begin
                fx[i] <= '0;
                fy[i] <= '0;
            end
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            min_x      <= min_n;
            max_x      <= max_n;
            max_y      <= maxy_n;
            off_x      <= offx_n;
            off_y      <= offy_n;
            dir        <= dir_n;
            cnt        <= cnt_n;
            fly_alive  <= alive_n;
            wave_clear <= wc_n;
            invaded    <= inv_n;
            ready      <= state_n inside {WAIT, SCAN, MOVE, CLEAR};
            if (load) begin
                for (int i = 0; i < FLY_COUNT; i++) begin
                    fx[i] <= px[i];
                    fy[i] <= py[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_fly_swarm_ctrl.sv
// tb_fly_swarm_ctrl: directed scenarios with hand-computed positions, masks and tick counts
module tb_fly_swarm_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, frame_tick = 1'b0;
    logic [159:0] fly_x_flat, fly_y_flat;
    logic [15:0] fly_alive;
    logic wave_clear, invaded;
    int checks = 0, errors = 0;

    fly_swarm_ctrl_if hif ();

    fly_swarm_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_tick(frame_tick), .hit(hif),
        .fly_x_flat(fly_x_flat), .fly_y_flat(fly_y_flat), .fly_alive(fly_alive),
        .wave_clear(wave_clear), .invaded(invaded)
    );

    always #5 clk = ~clk;

    function automatic int xo(int i);
        return int'(fly_x_flat[10*i +: 10]);
    endfunction
    function automatic int yo(int i);
        return int'(fly_y_flat[10*i +: 10]);
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask
    task automatic tick;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        repeat (19) cyc();
    endtask
    task automatic ticks(input int n);
        repeat (n) tick();
    endtask
    task automatic do_start;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask
    task automatic hit(input int i);
        hif.hit_valid = 1'b1;
        hif.hit_idx = 4'(i);
        cyc();
        hif.hit_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        hif.hit_valid = 1'b0;
        hif.hit_idx = '0;
        cyc();
        cyc();
        checks++; if (fly_alive !== 16'h0) begin errors++; $display("FAIL reset_alive got %h exp 0000", fly_alive); end
        checks++; if (fly_x_flat !== '0 || fly_y_flat !== '0) begin errors++; $display("FAIL reset_pos got x=%h y=%h exp 0", fly_x_flat, fly_y_flat); end
        checks++; if (wave_clear !== 1'b0 || invaded !== 1'b0 || hif.hit_ready !== 1'b0) begin errors++; $display("FAIL reset_flags got wc=%b inv=%b rdy=%b exp 0 0 0", wave_clear, invaded, hif.hit_ready); end
        rst_n = 1'b1;
        cyc();
        checks++; if (hif.hit_ready !== 1'b0 || fly_alive !== 16'h0) begin errors++; $display("FAIL idle_hold got rdy=%b alive=%h exp 0 0000", hif.hit_ready, fly_alive); end
    endtask

    task automatic test_start;
        do_start();
        checks++; if (fly_alive !== 16'hFFFF || hif.hit_ready !== 1'b1) begin errors++; $display("FAIL spawn got alive=%h rdy=%b exp ffff 1", fly_alive, hif.hit_ready); end
        checks++; if (xo(0) != 64 || yo(0) != 40 || xo(15) != 400 || yo(15) != 80) begin errors++; $display("FAIL spawn_pos got f0=(%0d,%0d) f15=(%0d,%0d) exp (64,40) (400,80)", xo(0), yo(0), xo(15), yo(15)); end
        tick();
        checks++; if (xo(0) != 66 || yo(0) != 40 || xo(15) != 402 || yo(15) != 80) begin errors++; $display("FAIL first_move got f0=(%0d,%0d) f15=(%0d,%0d) exp (66,40) (402,80)", xo(0), yo(0), xo(15), yo(15)); end
    endtask

    task automatic test_hit_twice;
        hit(3);
        checks++; if (fly_alive !== 16'hFFF7 || wave_clear !== 1'b0) begin errors++; $display("FAIL hit3 got alive=%h wc=%b exp fff7 0", fly_alive, wave_clear); end
        hit(3);
        checks++; if (fly_alive !== 16'hFFF7 || wave_clear !== 1'b0) begin errors++; $display("FAIL hit3_again got alive=%h wc=%b exp fff7 0", fly_alive, wave_clear); end
    endtask

    task automatic test_right_edge;
        ticks(103);
        checks++; if (xo(7) != 608 || yo(7) != 40) begin errors++; $display("FAIL at_edge got f7=(%0d,%0d) exp (608,40)", xo(7), yo(7)); end
        tick();
        checks++; if (xo(7) != 608 || yo(7) != 56 || xo(0) != 272) begin errors++; $display("FAIL bounce got f7=(%0d,%0d) f0x=%0d exp (608,56) 272", xo(7), yo(7), xo(0)); end
        tick();
        checks++; if (xo(7) != 606 || yo(7) != 56) begin errors++; $display("FAIL move_left got f7=(%0d,%0d) exp (606,56)", xo(7), yo(7)); end
    endtask

    task automatic test_wave_clear;
        for (int i = 0; i < 16; i++) begin
            if (i != 3) begin
                hit(i);
                checks++; if (wave_clear !== (i == 15)) begin errors++; $display("FAIL wc_kill%0d got %b exp %b", i, wave_clear, i == 15); end
            end
        end
        cyc();
        checks++; if (wave_clear !== 1'b0 || fly_alive !== 16'h0 || hif.hit_ready !== 1'b1) begin errors++; $display("FAIL clear_state got wc=%b alive=%h rdy=%b exp 0 0000 1", wave_clear, fly_alive, hif.hit_ready); end
        hit(5);
        checks++; if (wave_clear !== 1'b0 || fly_alive !== 16'h0) begin errors++; $display("FAIL clear_hit got wc=%b alive=%h exp 0 0000", wave_clear, fly_alive); end
        ticks(119);
        checks++; if (fly_alive !== 16'h0) begin errors++; $display("FAIL early_respawn got alive=%h exp 0000", fly_alive); end
        tick();
        checks++; if (fly_alive !== 16'hFFFF || xo(0) != 64 || yo(0) != 40 || xo(15) != 400 || yo(15) != 80) begin errors++; $display("FAIL respawn got alive=%h f0=(%0d,%0d) f15=(%0d,%0d) exp ffff (64,40) (400,80)", fly_alive, xo(0), yo(0), xo(15), yo(15)); end
    endtask

    task automatic test_col7;
        hit(7);
        hit(15);
        checks++; if (fly_alive !== 16'h7F7F) begin errors++; $display("FAIL kill_col7 got %h exp 7f7f", fly_alive); end
        ticks(128);
        checks++; if (xo(6) != 608 || yo(6) != 40) begin errors++; $display("FAIL col6_edge got f6=(%0d,%0d) exp (608,40)", xo(6), yo(6)); end
        tick();
        checks++; if (xo(6) != 608 || yo(6) != 56) begin errors++; $display("FAIL col6_bounce got f6=(%0d,%0d) exp (608,56)", xo(6), yo(6)); end
        tick();
        checks++; if (xo(6) != 606) begin errors++; $display("FAIL col6_left got %0d exp 606", xo(6)); end
        do_start();
        checks++; if (fly_alive !== 16'h7F7F || xo(6) != 606 || yo(6) != 56) begin errors++; $display("FAIL start_ignored got alive=%h f6=(%0d,%0d) exp 7f7f (606,56)", fly_alive, xo(6), yo(6)); end
    endtask

    task automatic test_invasion;
        int n;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        do_start();
        n = 0;
        while (invaded !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        checks++; if (n != 2708) begin errors++; $display("FAIL invade_ticks got %0d exp 2708", n); end
        checks++; if (invaded !== 1'b1 || hif.hit_ready !== 1'b0) begin errors++; $display("FAIL invade_flags got inv=%b rdy=%b exp 1 0", invaded, hif.hit_ready); end
        checks++; if (yo(8) != 400 || yo(0) != 360 || xo(0) != 0) begin errors++; $display("FAIL invade_pos got f8y=%0d f0=(%0d,%0d) exp 400 (0,360)", yo(8), xo(0), yo(0)); end
        ticks(2);
        hit(0);
        checks++; if (yo(8) != 400 || xo(0) != 0 || fly_alive !== 16'hFFFF) begin errors++; $display("FAIL frozen got f8y=%0d f0x=%0d alive=%h exp 400 0 ffff", yo(8), xo(0), fly_alive); end
        do_start();
        checks++; if (invaded !== 1'b0 || hif.hit_ready !== 1'b1 || xo(0) != 64 || yo(8) != 80) begin errors++; $display("FAIL restart got inv=%b rdy=%b f0x=%0d f8y=%0d exp 0 1 64 80", invaded, hif.hit_ready, xo(0), yo(8)); end
    endtask

    task automatic test_reset_mid_scan;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        repeat (5) cyc();
        rst_n = 1'b0;
        cyc();
        checks++; if (fly_alive !== 16'h0 || hif.hit_ready !== 1'b0 || fly_x_flat !== '0 || invaded !== 1'b0) begin errors++; $display("FAIL mid_scan_reset got alive=%h rdy=%b f0x=%0d inv=%b exp 0000 0 0 0", fly_alive, hif.hit_ready, xo(0), invaded); end
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit_twice();
        test_right_edge();
        test_wave_clear();
        test_col7();
        test_invasion();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
